mc_controller: RTL and testbench

Control unit for the multicycle MIPS processor: a Moore FSM plus ALU decoder that sits directly upstream of the multicycle datapath.
- Takes op/funct from the datapath's instruction register and zero from its ALU.
- Drives every mux select and write enable in the datapath, one state per cycle.
- Replaces the single-cycle combinational controller; the ALU control encoding is unchanged.

---
 rtl/mc_controller.sv | 192 +++++++++++++++++++
 tb/tb_mc_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the datapath plus ALU decoder.
// Optional bne support is enabled by defining MC_BNE_EN.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    state_e state_q, state_d;
    logic   pc_write;
    logic   branch;
`ifdef MC_BNE_EN
    logic   bne_branch;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = StFetch;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b010;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        illegal_op  = 1'b0;
`ifdef MC_BNE_EN
        bne_branch  = 1'b0;
`endif

        case (state_q)
            StFetch: begin
                state_d   = StDecode;
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
`ifdef MC_BNE_EN
                    OpBne:      state_d = StBranch;
`endif
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                state_d   = (op == OpSw) ? StMemWr : StMemRd;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                state_d = StMemWb;
                iord    = 1'b1;
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            StExecute: begin
                state_d   = StAluWb;
                alu_src_a = 1'b1;
                case (funct)
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            StAluWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            StBranch: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
`ifdef MC_BNE_EN
                // beq and bne share this state; op picks the sense of zero
                branch      = (op != OpBne);
                bne_branch  = (op == OpBne);
`else
                branch      = 1'b1;
`endif
            end
            StAddiEx: begin
                state_d   = StAddiWb;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StAddiWb: begin
                reg_write = 1'b1;
            end
            StJump: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = StFetch;
        endcase

`ifdef MC_BNE_EN
        pc_en = pc_write | (branch & zero) | (bne_branch & ~zero);
`else
        pc_en = pc_write | (branch & zero);
`endif

        // Hold the datapath quiescent with FETCH selects while in reset
        if (!reset) begin
            iord        = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b01;
            alu_control = 3'b010;
            pc_src      = 2'b00;
            pc_en       = 1'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; expected values are hand-derived.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    mc_controller dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] exp_st);
        @(posedge clk);
        #1;
        chk(tag, 32'(state), exp_st);
    endtask

    initial begin
        logic [5:0] fn_tab [4];
        logic [2:0] ac_tab [4];
        fn_tab = '{6'b100010, 6'b101010, 6'b100101, 6'b111111};
        ac_tab = '{3'b110, 3'b111, 3'b001, 3'b010};

        // Reset held for two edges
        reset = 1'b0;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk);
        step("rst_state", 0);
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_ir_write", 32'(ir_write), 0);
        chk("rst_reg_write", 32'(reg_write), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_alu_src_b", 32'(alu_src_b), 1);
        reset = 1'b1;
        #1;
        chk("fetch_pc_en", 32'(pc_en), 1);
        chk("fetch_ir_write", 32'(ir_write), 1);
        chk("fetch_alu_src_b", 32'(alu_src_b), 1);
        chk("fetch_pc_src", 32'(pc_src), 0);

        // lw: 0,1,2,3,4,0
        step("lw_decode", 1);
        chk("lw_dec_alu_src_b", 32'(alu_src_b), 3);
        chk("lw_dec_illegal", 32'(illegal_op), 0);
        step("lw_memadr", 2);
        chk("lw_adr_src_a", 32'(alu_src_a), 1);
        chk("lw_adr_src_b", 32'(alu_src_b), 2);
        step("lw_memrd", 3);
        chk("lw_rd_iord", 32'(iord), 1);
        step("lw_memwb", 4);
        chk("lw_wb_reg_write", 32'(reg_write), 1);
        chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
        chk("lw_wb_reg_dst", 32'(reg_dst), 0);
        step("lw_fetch", 0);

        // sw: 0,1,2,5,0
        op = 6'b101011;
        step("sw_decode", 1);
        chk("sw_dec_mem_write", 32'(mem_write), 0);
        step("sw_memadr", 2);
        chk("sw_adr_mem_write", 32'(mem_write), 0);
        step("sw_memwr", 5);
        chk("sw_wr_mem_write", 32'(mem_write), 1);
        chk("sw_wr_iord", 32'(iord), 1);
        step("sw_fetch", 0);
        chk("sw_fetch_mem_write", 32'(mem_write), 0);

        // R-type with several funct codes
        op = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            funct = fn_tab[i];
            step("r_decode", 1);
            step("r_execute", 6);
            chk("r_alu_control", 32'(alu_control), 32'(ac_tab[i]));
            chk("r_alu_src_a", 32'(alu_src_a), 1);
            step("r_aluwb", 7);
            chk("r_wb_reg_dst", 32'(reg_dst), 1);
            chk("r_wb_reg_write", 32'(reg_write), 1);
            step("r_fetch", 0);
        end

        // beq taken then not taken
        op = 6'b000100;
        zero = 1'b1;
        step("beq_decode", 1);
        step("beq_branch", 8);
        chk("beq_taken_pc_en", 32'(pc_en), 1);
        chk("beq_pc_src", 32'(pc_src), 1);
        chk("beq_alu_control", 32'(alu_control), 6);
        step("beq_fetch", 0);
        zero = 1'b0;
        step("beq2_decode", 1);
        step("beq2_branch", 8);
        chk("beq_not_taken_pc_en", 32'(pc_en), 0);
        step("beq2_fetch", 0);

        // addi: 0,1,9,10,0
        op = 6'b001000;
        step("addi_decode", 1);
        step("addi_ex", 9);
        chk("addi_src_b", 32'(alu_src_b), 2);
        step("addi_wb", 10);
        chk("addi_reg_write", 32'(reg_write), 1);
        chk("addi_reg_dst", 32'(reg_dst), 0);
        step("addi_fetch", 0);

        // j
        op = 6'b000010;
        step("j_decode", 1);
        step("j_jump", 11);
        chk("j_pc_src", 32'(pc_src), 2);
        chk("j_pc_en", 32'(pc_en), 1);
        step("j_fetch", 0);

        // illegal opcode
        op = 6'b111111;
        step("ill_decode", 1);
        chk("ill_illegal_op", 32'(illegal_op), 1);
        step("ill_fetch", 0);
        chk("ill_fetch_illegal_op", 32'(illegal_op), 0);

        // bne: branch when enabled, illegal otherwise
        op = 6'b000101;
        zero = 1'b0;
`ifdef MC_BNE_EN
        step("bne_decode", 1);
        chk("bne_illegal_op", 32'(illegal_op), 0);
        step("bne_branch", 8);
        chk("bne_taken_pc_en", 32'(pc_en), 1);
        zero = 1'b1;
        #1;
        chk("bne_not_taken_pc_en", 32'(pc_en), 0);
        step("bne_fetch", 0);
`else
        step("bne_decode", 1);
        chk("bne_illegal_op", 32'(illegal_op), 1);
        step("bne_fetch", 0);
`endif

        // Reset in MEMRD aborts the lw before MEMWB
        op = 6'b100011;
        zero = 1'b0;
        step("mid_decode", 1);
        step("mid_memadr", 2);
        step("mid_memrd", 3);
        reset = 1'b0;
        #1;
        chk("mid_rst_reg_write", 32'(reg_write), 0);
        chk("mid_rst_iord", 32'(iord), 0);
        chk("mid_rst_pc_en", 32'(pc_en), 0);
        step("mid_rst_state", 0);
        chk("mid_rst2_reg_write", 32'(reg_write), 0);
        reset = 1'b1;
        #1;
        chk("mid_rel_reg_write", 32'(reg_write), 0);
        chk("mid_rel_ir_write", 32'(ir_write), 1);
        step("mid_rel_decode", 1);
        chk("mid_dec_reg_write", 32'(reg_write), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
